pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central pipeline control for the 5-stage core; consumes the load-use stall request from hazard detection plus branch/jump, data-memory and mul/div events.
- Produces per-stage hold (keep register contents) and flush (insert bubble) controls for PC, IF/ID, ID/EX and EX/MEM.
- Owns the multi-cycle wait FSM, a memory-wait watchdog and saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 64, max consecutive MEM_WAIT cycles before watchdog fires (>=2)
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- stall_req  input  1  load-use stall request from hazard detection (combinational, ID stage)
- jump_ex  input  1  taken branch/jump resolved in EX
- mem_req_ex  input  1  EX-stage instruction issues data-memory access
- mem_ack  input  1  data memory accepts/completes access this cycle
- md_start  input  1  EX-stage mul/div begins
- md_done  input  1  mul/div result valid this cycle
- hold_pc  output  1  PC holds value
- hold_if_id  output  1  IF/ID register holds
- hold_id_ex  output  1  ID/EX register holds
- flush_if_id  output  1  IF/ID loads bubble
- flush_id_ex  output  1  ID/EX loads bubble
- flush_ex_mem  output  1  EX/MEM loads bubble
- mem_timeout  output  1  sticky watchdog flag
- stall_cnt  output  CNT_W  cycles with hold_pc high
- flush_cnt  output  CNT_W  jump flush events

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While rst=1: hold_* = 0, flush_* = 1, state=RUN, wait counter=0, mem_timeout=0, stall_cnt=flush_cnt=0. Reset mid-wait aborts the wait and returns to RUN next cycle.
- Outputs are combinational from state and inputs (zero latency). Counters and state are registered.
- Default (no condition active): all outputs 0.
- FSM states: RUN, MEM_WAIT, MD_WAIT.
- RUN, priority high to low:
  1. mem_req_ex & !mem_ack: hold_pc, hold_if_id, hold_id_ex, flush_ex_mem = 1; next MEM_WAIT.
  2. md_start & !md_done: same outputs as 1; next MD_WAIT.
  3. jump_ex: flush_if_id = flush_id_ex = 1, no holds; flush_cnt += 1. stall_req is ignored (wrong-path instruction).
  4. stall_req: hold_pc = hold_if_id = 1, flush_id_ex = 1.
  - mem_req_ex & mem_ack, or md_start & md_done, in the same cycle completes without a wait; evaluate 3 and 4 normally.
- MEM_WAIT:
  - Asserts the same outputs as RUN rule 1 each cycle until mem_ack=1.
  - On the mem_ack cycle: the mem-wait holds and flush_ex_mem deassert; rules 3 and 4 are evaluated; next RUN.
  - A wait counter increments each MEM_WAIT cycle and clears on exit. When it reaches TIMEOUT-1 without ack, mem_timeout is set (sticky until rst), the FSM returns to RUN and the holds drop.
- MD_WAIT: same as MEM_WAIT, keyed on md_done, with no watchdog.
- jump_ex arriving during a wait is not acted on until the release cycle; the EX instruction is held, so jump_ex is still asserted then.
- Counters:
  - stall_cnt increments every cycle hold_pc=1.
  - flush_cnt increments once per cycle in which the jump flush is asserted.
  - Both saturate at all-ones; no wrap.
- Invariant: a hold and a flush are never both asserted on the same register.

Test Plan:
- Reset: rst=1 for 2 cycles -> flush_* = 1, hold_* = 0, counters 0; after release with all inputs 0, all outputs 0.
- Load-use: stall_req=1 for 1 cycle in RUN -> hold_pc = hold_if_id = flush_id_ex = 1 that cycle; stall_cnt = 1.
- Jump beats stall: jump_ex = stall_req = 1 -> flush_if_id = flush_id_ex = 1, hold_pc = 0; flush_cnt = 1, stall_cnt unchanged.
- Memory wait: mem_req_ex=1 with ack 3 cycles later -> holds and flush_ex_mem high for 3 cycles, low on the ack cycle; state back to RUN; stall_cnt = 3.
- Watchdog: mem_req_ex=1, mem_ack never -> mem_timeout rises after TIMEOUT (64) wait cycles and stays high; holds drop; a subsequent rst clears it.
- Mul/div: md_start=1, md_done after 5 cycles, with jump_ex held high throughout -> 5 hold cycles with no flush_if_id; on the done cycle flush_if_id = flush_id_ex = 1 and flush_cnt += 1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central hold/flush control for the 5-stage pipeline: multi-cycle wait FSM,
// data-memory watchdog and saturating stall/flush performance counters.
module pipeline_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             jump_ex,
    input  logic             mem_req_ex,
    input  logic             mem_ack,
    input  logic             md_start,
    input  logic             md_done,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             hold_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              timeout_reg, timeout_next;
    logic              wait_hold;
    logic              release_ok;
    logic              jump_flush;
    logic              stall_hold;

    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        timeout_next = timeout_reg;
        wait_hold    = 1'b0;
        release_ok   = 1'b0;
        case (state_reg)
            RUN: begin
                if (mem_req_ex && !mem_ack) begin
                    wait_hold  = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = '0;
                end else if (md_start && !md_done) begin
                    wait_hold  = 1'b1;
                    state_next = MD_WAIT;
                end else begin
                    release_ok = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    release_ok = 1'b1;
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    wait_hold = 1'b1;
                    // Give up on a memory that never answers so the core can't deadlock.
                    if (wait_reg == WAIT_LAST) begin
                        timeout_next = 1'b1;
                        state_next   = RUN;
                        wait_next    = '0;
                    end else begin
                        wait_next = wait_reg + 1'b1;
                    end
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    release_ok = 1'b1;
                    state_next = RUN;
                end else begin
                    wait_hold = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
        // A taken jump squashes the younger instruction, so its load-use stall is moot.
        jump_flush = release_ok && jump_ex;
        stall_hold = release_ok && !jump_ex && stall_req;
    end

    assign hold_pc      = !rst && (wait_hold || stall_hold);
    assign hold_if_id   = !rst && (wait_hold || stall_hold);
    assign hold_id_ex   = !rst && wait_hold;
    assign flush_if_id  = rst || jump_flush;
    assign flush_id_ex  = rst || jump_flush || stall_hold;
    assign flush_ex_mem = rst || wait_hold;
    assign mem_timeout  = timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RUN;
            wait_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            timeout_reg <= timeout_next;
        end
    end

    logic [CNT_W-1:0] cnt_reg [2];
    logic             cnt_inc [2];

    assign cnt_inc[0] = hold_pc;
    assign cnt_inc[1] = !rst && jump_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule
